// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared FSM encoding, zero-register default and forward selects
// Rev 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDUSE   = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_t;

  localparam int ZERO_REG_DEFAULT = 31;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // MEM stage holds the youngest value, so it wins over WB.
  function automatic logic [1:0] fwd_sel(
    input logic       mem_we,
    input logic [4:0] mem_rd,
    input logic       wb_we,
    input logic [4:0] wb_rd,
    input logic [4:0] src,
    input logic [4:0] zero_reg
  );
    if (mem_we && (mem_rd != zero_reg) && (mem_rd == src)) begin
      return FWD_MEM;
    end else if (wb_we && (wb_rd != zero_reg) && (wb_rd == src)) begin
      return FWD_WB;
    end else begin
      return FWD_REG;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/forwarding_unit.sv
// ============================================================================
// forwarding_unit : combinational ALU operand source select (MEM > WB > REG)
// Rev 1.0
// ============================================================================
`default_nettype none

module forwarding_unit
  import hazard_pkg::*;
#(
  parameter int ZERO_REG = ZERO_REG_DEFAULT
) (
  input  logic       i_mem_reg_write,
  input  logic [4:0] i_mem_rd,
  input  logic       i_wb_reg_write,
  input  logic [4:0] i_wb_rd,
  input  logic [4:0] i_ex_rn1,
  input  logic [4:0] i_ex_rn2,
  output logic [1:0] o_forward_a,
  output logic [1:0] o_forward_b
);

  localparam logic [4:0] C_ZERO = 5'(ZERO_REG);

  assign o_forward_a = fwd_sel(i_mem_reg_write, i_mem_rd, i_wb_reg_write, i_wb_rd, i_ex_rn1, C_ZERO);
  assign o_forward_b = fwd_sel(i_mem_reg_write, i_mem_rd, i_wb_reg_write, i_wb_rd, i_ex_rn2, C_ZERO);

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl : load-use stall, branch flush and memory-wait freeze
// control with operand forwarding. Optional macro HAZARD_PERF_CNT_EN adds
// StallCount/FlushCount performance counters.
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int ZERO_REG   = ZERO_REG_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IDValid,
  input  logic [4:0]  IDRn1,
  input  logic [4:0]  IDRn2,
  input  logic        EXMemRead,
  input  logic [4:0]  EXRd,
  input  logic [4:0]  EXRn1,
  input  logic [4:0]  EXRn2,
  input  logic        MEMRegWrite,
  input  logic [4:0]  MEMRd,
  input  logic        WBRegWrite,
  input  logic [4:0]  WBRd,
  input  logic        PCSrc,
  input  logic        DMemBusy,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXBubble,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        PipeFreeze,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  localparam logic [4:0] C_ZERO       = 5'(ZERO_REG);
  localparam logic [1:0] C_STALL_INIT = 2'(LOAD_STALL - 1);

  state_t     r_state;
  logic [1:0] r_stall_cnt;

  state_t     w_eff_state;
  state_t     w_next_state;
  logic [1:0] w_next_cnt;
  logic       w_hazard;
  logic       w_pcwrite, w_ifidwrite, w_bubble, w_ifidflush, w_idexflush, w_freeze;

  assign w_hazard = IDValid & EXMemRead & (EXRd != C_ZERO) & ((EXRd == IDRn1) | (EXRd == IDRn2));

  // Leaving MEMWAIT applies the resumed state's rules in the same cycle.
  always_comb begin
    w_eff_state = r_state;
    if (r_state == ST_MEMWAIT) begin
      w_eff_state = (r_stall_cnt != 2'd0) ? ST_LDUSE : ST_RUN;
    end
  end

  always_comb begin
    w_pcwrite    = 1'b1;
    w_ifidwrite  = 1'b1;
    w_bubble     = 1'b0;
    w_ifidflush  = 1'b0;
    w_idexflush  = 1'b0;
    w_freeze     = 1'b0;
    w_next_state = ST_RUN;
    w_next_cnt   = r_stall_cnt;
    if (DMemBusy) begin
      w_freeze     = 1'b1;
      w_pcwrite    = 1'b0;
      w_ifidwrite  = 1'b0;
      w_next_state = ST_MEMWAIT;
    end else if (PCSrc) begin
      w_ifidflush  = 1'b1;
      w_idexflush  = 1'b1;
      w_next_cnt   = 2'd0;
    end else if (w_eff_state == ST_LDUSE) begin
      w_pcwrite    = 1'b0;
      w_ifidwrite  = 1'b0;
      w_bubble     = 1'b1;
      w_next_cnt   = r_stall_cnt - 2'd1;
      w_next_state = (r_stall_cnt == 2'd1) ? ST_RUN : ST_LDUSE;
    end else if (w_hazard) begin
      w_pcwrite    = 1'b0;
      w_ifidwrite  = 1'b0;
      w_bubble     = 1'b1;
      if (LOAD_STALL > 1) begin
        w_next_state = ST_LDUSE;
        w_next_cnt   = C_STALL_INIT;
      end else begin
        w_next_cnt   = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= 2'd0;
    end else begin
      r_state     <= w_next_state;
      r_stall_cnt <= w_next_cnt;
    end
  end

  // Reset forces the idle RUN outputs without waiting for a clock edge.
  assign PCWrite    = reset | w_pcwrite;
  assign IFIDWrite  = reset | w_ifidwrite;
  assign IDEXBubble = ~reset & w_bubble;
  assign IFIDFlush  = ~reset & w_ifidflush;
  assign IDEXFlush  = ~reset & w_idexflush;
  assign PipeFreeze = ~reset & w_freeze;

  forwarding_unit #(
    .ZERO_REG (ZERO_REG)
  ) u_fwd (
    .i_mem_reg_write (MEMRegWrite),
    .i_mem_rd        (MEMRd),
    .i_wb_reg_write  (WBRegWrite),
    .i_wb_rd         (WBRd),
    .i_ex_rn1        (EXRn1),
    .i_ex_rn2        (EXRn2),
    .o_forward_a     (ForwardA),
    .o_forward_b     (ForwardB)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= 32'd0;
      r_flush_count <= 32'd0;
    end else begin
      r_stall_count <= r_stall_count + {31'd0, IDEXBubble};
      r_flush_count <= r_flush_count + {31'd0, IDEXFlush};
    end
  end

  assign StallCount = r_stall_count;
  assign FlushCount = r_flush_count;
`endif

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter LOAD_STALL, default 1, load-use stall length in cycles (legal 1..3).
REQ-002 Parameter ZERO_REG, default 31, register index (XZR) that never causes a hazard or forward.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 IDValid, IDRn1[4:0], IDRn2[4:0]  in  ID-stage instruction valid and source registers.
REQ-006 EXMemRead, EXRd[4:0], EXRn1[4:0], EXRn2[4:0]  in  EX-stage load flag, destination, operand sources.
REQ-007 MEMRegWrite, MEMRd[4:0], WBRegWrite, WBRd[4:0]  in  later-stage writeback info for forwarding.
REQ-008 PCSrc  in  1  taken branch resolved in MEM stage.
REQ-009 DMemBusy  in  1  data memory not ready; MEM access must hold.
REQ-010 PCWrite, IFIDWrite  out  1  enable PC / IF-ID register update.
REQ-011 IDEXBubble  out  1  load zero control into ID/EX (bubble).
REQ-012 IFIDFlush, IDEXFlush  out  1  squash IF/ID and ID/EX contents.
REQ-013 PipeFreeze  out  1  hold every pipeline register (IF/ID through MEM/WB).
REQ-014 ForwardA[1:0], ForwardB[1:0]  out  ALU operand source select for Data1/ALUInput2 path.

Function
REQ-015 Hazard = IDValid & EXMemRead & EXRd!=ZERO_REG & (EXRd==IDRn1 | EXRd==IDRn2), combinational.
REQ-016 FSM states RUN, LDUSE, MEMWAIT; per-cycle priority: DMemBusy > PCSrc > Hazard.
REQ-017 RUN, no event: PCWrite=1, IFIDWrite=1, all other control outputs 0.
REQ-018 RUN & Hazard: PCWrite=0, IFIDWrite=0, IDEXBubble=1 same cycle; if LOAD_STALL>1 go LDUSE with StallCnt=LOAD_STALL-1, else stay RUN.
REQ-019 LDUSE: stall outputs as REQ-018; StallCnt decrements each cycle; go RUN on the cycle StallCnt==1; total stall exactly LOAD_STALL cycles.
REQ-020 DMemBusy=1 in any state: PipeFreeze=1, PCWrite=0, IFIDWrite=0, no flush/bubble; enter/stay MEMWAIT; StallCnt frozen.
REQ-021 MEMWAIT & DMemBusy=0: PipeFreeze=0 that cycle; resume LDUSE if StallCnt!=0 else RUN, applying that state's rules combinationally the same cycle.
REQ-022 PCSrc=1 (DMemBusy=0), any state: PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXFlush=1, IDEXBubble=0, StallCnt cleared, next RUN; coincident Hazard ignored.
REQ-023 ForwardA: 2'b10 if MEMRegWrite & MEMRd!=ZERO_REG & MEMRd==EXRn1; else 2'b01 if WBRegWrite & WBRd!=ZERO_REG & WBRd==EXRn1; else 2'b00. ForwardB identical on EXRn2.
REQ-024 Forward selects are combinational, independent of FSM state, and unaffected by PipeFreeze.

Reset
REQ-025 reset asserted (any time, mid-stall included): state RUN, StallCnt=0, counters 0; outputs immediately PCWrite=1, IFIDWrite=1, others 0.
REQ-026 First rising edge after reset release evaluates events normally.

Configuration
REQ-027 Macro HAZARD_PERF_CNT_EN defined: adds outputs StallCount[31:0] (+1 each cycle IDEXBubble=1) and FlushCount[31:0] (+1 each cycle IDEXFlush=1), both wrap 32'hFFFFFFFF->0, held during PipeFreeze.
REQ-028 Macro undefined: those ports and registers are absent; all other behaviour identical.

Structure
REQ-029 Shared package hazard_pkg holds FSM state encoding, ZERO_REG default, and forward-select constants FWD_REG=00, FWD_WB=01, FWD_MEM=10.
REQ-030 Forwarding logic (REQ-023) is sub-module forwarding_unit; FSM and counters stay in top.

Verification
REQ-031 LOAD_STALL=1, EXMemRead=1, EXRd=5, IDRn1=5 -> one cycle PCWrite=0, IDEXBubble=1, then RUN; EXRd=31 instead -> no stall.
REQ-032 LOAD_STALL=3, hazard then DMemBusy high 4 cycles in 2nd stall cycle -> PipeFreeze 4 cycles, then remaining 2 stall cycles, total bubbles 3.
REQ-033 Hazard and PCSrc same cycle -> IFIDFlush=IDEXFlush=1, PCWrite=1, IDEXBubble=0, next cycle RUN.
REQ-034 MEMRd=WBRd=EXRn1=7, both RegWrite=1 -> ForwardA=10; MEMRegWrite=0 -> 01; MEMRd=WBRd=31 -> 00.
REQ-035 reset asserted mid-LDUSE (LOAD_STALL=3) -> outputs return to RUN values without clock edge; no stall after release.
REQ-036 HAZARD_PERF_CNT_EN, StallCount preset 32'hFFFFFFFF via force, one bubble -> 0.
